simon_iter_engine: RTL and testbench

Iterative Simon block-cipher engine for both SIMON_MODE_64_128 (32-bit words, 44 rounds) and SIMON_MODE_128_128 (64-bit words, 68 rounds).
- Supports encrypt and decrypt, executing one round per cycle.
- Fetches round keys from an external expanded-key store (the simon_kexp output, registered into a RAM) over a 1-cycle-latency read port.
- Sits between the key expander and the system-level valid/ready datapath.
- Replaces testbench-driven round sequencing with a self-contained, handshaked core.

---
 rtl/simon_iter_engine_pkg.sv | 25 ++
 rtl/simon_round_fn.sv | 54 +++++
 rtl/simon_iter_engine.sv | 137 +++++++++++++
 tb/tb_simon_iter_engine.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_iter_engine_pkg.sv
// Shared constants, FSM state encoding and round-count helper for the
// iterative Simon engine and its round function.
package simon_iter_engine_pkg;

    localparam logic SIMON_MODE_64_128  = 1'b0;
    localparam logic SIMON_MODE_128_128 = 1'b1;

    localparam int SIMON_64_128_ROUNDS  = 44;
    localparam int SIMON_128_128_ROUNDS = 68;

    localparam int SIMON_64_WORD_W  = 32;
    localparam int SIMON_128_WORD_W = 64;

    typedef enum logic [1:0] {
        SIMON_ENG_IDLE,
        SIMON_ENG_LOAD,
        SIMON_ENG_RUN,
        SIMON_ENG_DONE
    } simon_eng_state_e;

    function automatic int simon_rounds(input logic mode);
        return (mode == SIMON_MODE_128_128) ? SIMON_128_128_ROUNDS : SIMON_64_128_ROUNDS;
    endfunction

endpackage

// File: rtl/simon_round_fn.sv
// One combinational Simon round (encrypt or decrypt) for 32- or 64-bit words;
// in 32-bit mode everything above bit 31 is forced to zero.
module simon_round_fn
    import simon_iter_engine_pkg::*;
#(
    parameter int MAX_WORD_W = 64
) (
    input  logic                  mode,
    input  logic                  enc_dec,
    input  logic [MAX_WORD_W-1:0] x,
    input  logic [MAX_WORD_W-1:0] y,
    input  logic [MAX_WORD_W-1:0] k,
    output logic [MAX_WORD_W-1:0] x_nx,
    output logic [MAX_WORD_W-1:0] y_nx
);

    typedef logic [MAX_WORD_W-1:0]      word_t;
    typedef logic [SIMON_64_WORD_W-1:0] half_t;

    logic  wide;
    word_t mask;
    word_t km;

    assign wide = (MAX_WORD_W >= SIMON_128_WORD_W) && (mode == SIMON_MODE_128_128);

    function automatic word_t rotl(input word_t a, input int n, input logic wd);
        half_t a32;
        word_t r;
        a32 = a[SIMON_64_WORD_W-1:0];
        r = '0;
        r[SIMON_64_WORD_W-1:0] = (a32 << n) | (a32 >> (SIMON_64_WORD_W - n));
        if (wd) r = (a << n) | (a >> (MAX_WORD_W - n));
        return r;
    endfunction

    function automatic word_t simon_f(input word_t a, input logic wd);
        return (rotl(a, 1, wd) & rotl(a, 8, wd)) ^ rotl(a, 2, wd);
    endfunction

    always_comb begin
        mask = '0;
        mask[SIMON_64_WORD_W-1:0] = '1;
        if (wide) mask = '1;
        km = k & mask;
        if (enc_dec) begin
            x_nx = (y ^ simon_f(x, wide) ^ km) & mask;
            y_nx = x & mask;
        end else begin
            x_nx = y & mask;
            y_nx = (x ^ simon_f(y, wide) ^ km) & mask;
        end
    end

endmodule

// File: rtl/simon_iter_engine.sv
// Iterative Simon 64/128 and 128/128 engine: one round per cycle, round keys
// fetched from an external expanded-key RAM with one cycle of read latency.
module simon_iter_engine
    import simon_iter_engine_pkg::*;
#(
    parameter int MAX_WORD_W  = 64,
    parameter int KEY_ADDR_W  = 7,
    parameter bit SUPPORT_128 = 1'b1
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  enc_dec,
    input  logic [MAX_WORD_W-1:0] x_in,
    input  logic [MAX_WORD_W-1:0] y_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  keys_valid,
    output logic [KEY_ADDR_W-1:0] key_addr,
    input  logic [MAX_WORD_W-1:0] key_data,
    output logic [MAX_WORD_W-1:0] x_out,
    output logic [MAX_WORD_W-1:0] y_out,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef logic [MAX_WORD_W-1:0] word_t;
    typedef logic [KEY_ADDR_W-1:0] addr_t;

    localparam bit HAS_128 = SUPPORT_128 && (MAX_WORD_W >= SIMON_128_WORD_W);

    simon_eng_state_e state, state_nx;

    logic  mode_r, enc_r, mode_eff, accept, unsup_in;
    word_t x_r, y_r, x_nx, y_nx, in_mask;
    addr_t rounds_r, rounds_in, cnt, addr_adv;

    assign unsup_in  = (mode == SIMON_MODE_128_128) && !HAS_128;
    assign in_ready  = !rst && (state == SIMON_ENG_IDLE) && keys_valid;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == SIMON_ENG_DONE);
    assign rounds_in = addr_t'(simon_rounds(mode));
    assign mode_eff  = HAS_128 ? mode_r : SIMON_MODE_64_128;

    always_comb begin
        in_mask = '0;
        in_mask[SIMON_64_WORD_W-1:0] = '1;
        if (mode == SIMON_MODE_128_128 && HAS_128) in_mask = '1;
    end

    // The prefetch after the last round is never used, so saturate at either end.
    always_comb begin
        addr_adv = key_addr;
        if (enc_r) begin
            if (key_addr != rounds_r - addr_t'(1)) addr_adv = key_addr + addr_t'(1);
        end else begin
            if (key_addr != '0) addr_adv = key_addr - addr_t'(1);
        end
    end

    simon_round_fn #(
        .MAX_WORD_W(MAX_WORD_W)
    ) u_round (
        .mode   (mode_eff),
        .enc_dec(enc_r),
        .x      (x_r),
        .y      (y_r),
        .k      (key_data),
        .x_nx   (x_nx),
        .y_nx   (y_nx)
    );

    always_ff @(posedge ck) begin
        if (rst) state <= SIMON_ENG_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SIMON_ENG_IDLE: if (accept) state_nx = unsup_in ? SIMON_ENG_DONE : SIMON_ENG_LOAD;
            SIMON_ENG_LOAD: state_nx = SIMON_ENG_RUN;
            SIMON_ENG_RUN:  if (cnt == addr_t'(1)) state_nx = SIMON_ENG_DONE;
            SIMON_ENG_DONE: if (out_ready) state_nx = SIMON_ENG_IDLE;
            default:        state_nx = SIMON_ENG_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            key_addr <= '0;
            cnt      <= '0;
            out_err  <= 1'b0;
            x_out    <= '0;
            y_out    <= '0;
        end else begin
            case (state)
                SIMON_ENG_IDLE: if (accept) begin
                    out_err  <= unsup_in;
                    x_out    <= '0;
                    y_out    <= '0;
                    key_addr <= (enc_dec || unsup_in) ? '0 : rounds_in - addr_t'(1);
                end
                SIMON_ENG_LOAD: begin
                    key_addr <= addr_adv;
                    cnt      <= rounds_r;
                end
                SIMON_ENG_RUN: begin
                    key_addr <= addr_adv;
                    cnt      <= cnt - addr_t'(1);
                    if (cnt == addr_t'(1)) begin
                        x_out <= x_nx;
                        y_out <= y_nx;
                    end
                end
                SIMON_ENG_DONE: if (out_ready) out_err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Block state carries no reset; it is reloaded on every accept.
    always_ff @(posedge ck) begin
        if (accept) begin
            mode_r   <= mode;
            enc_r    <= enc_dec;
            rounds_r <= rounds_in;
            x_r      <= x_in & in_mask;
            y_r      <= y_in & in_mask;
        end else if (state == SIMON_ENG_RUN) begin
            x_r <= x_nx;
            y_r <= y_nx;
        end
    end

endmodule

// File: tb/tb_simon_iter_engine.sv
// Bench for simon_iter_engine: known-answer vectors, random blocks against a
// behavioural Simon model, backpressure, mid-run reset, unsupported mode.
module tb_simon_iter_engine;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic        rst, mode, enc_dec, in_valid, in_ready, keys_valid;
    logic        out_err, out_valid, out_ready;
    logic [63:0] x_in, y_in, key_data, x_out, y_out;
    logic [6:0]  key_addr;

    logic        mode2, in_valid2, in_ready2, keys_valid2, out_err2, out_valid2, out_ready2;
    logic [63:0] key_data2, x_out2, y_out2;
    logic [6:0]  key_addr2;

    int checks = 0;
    int errors = 0;

    logic [63:0] kmem [0:67];
    logic [63:0] rk   [0:67];

    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    simon_iter_engine #(.MAX_WORD_W(64), .KEY_ADDR_W(7), .SUPPORT_128(1'b1)) u_dut (
        .ck(ck), .rst(rst), .mode(mode), .enc_dec(enc_dec), .x_in(x_in), .y_in(y_in),
        .in_valid(in_valid), .in_ready(in_ready), .keys_valid(keys_valid),
        .key_addr(key_addr), .key_data(key_data), .x_out(x_out), .y_out(y_out),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    simon_iter_engine #(.MAX_WORD_W(64), .KEY_ADDR_W(7), .SUPPORT_128(1'b0)) u_dut_ns (
        .ck(ck), .rst(rst), .mode(mode2), .enc_dec(enc_dec), .x_in(x_in), .y_in(y_in),
        .in_valid(in_valid2), .in_ready(in_ready2), .keys_valid(keys_valid2),
        .key_addr(key_addr2), .key_data(key_data2), .x_out(x_out2), .y_out(y_out2),
        .out_err(out_err2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    // Registered key RAM read port shared by both engines.
    always @(posedge ck) begin
        key_data  <= kmem[key_addr];
        key_data2 <= kmem[key_addr2];
    end

    function automatic logic [63:0] rl(input logic [63:0] a, input int n, input int w);
        logic [31:0] a32;
        a32 = a[31:0];
        if (w == 32) return {32'h0, (a32 << n) | (a32 >> (32 - n))};
        return (a << n) | (a >> (64 - n));
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] a, input int n, input int w);
        return rl(a, w - n, w);
    endfunction

    function automatic logic [63:0] ff(input logic [63:0] a, input int w);
        return (rl(a, 1, w) & rl(a, 8, w)) ^ rl(a, 2, w);
    endfunction

    // Standard Simon key schedule, written into both the RAM and the model copy.
    task automatic load_keys(input logic m, input logic [63:0] k0, k1, k2, k3);
        logic [61:0] z;
        logic [63:0] msk, c, tmp;
        int w, mm, nr;
        w  = m ? 64 : 32;
        mm = m ? 2 : 4;
        nr = m ? 68 : 44;
        z  = m ? Z2 : Z3;
        msk = m ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        c = msk ^ 64'h3;
        @(negedge ck);
        keys_valid = 1'b0;
        rk[0] = k0 & msk; rk[1] = k1 & msk; rk[2] = k2 & msk; rk[3] = k3 & msk;
        for (int i = mm; i < nr; i++) begin
            tmp = rr(rk[i-1], 3, w);
            if (mm == 4) tmp = tmp ^ rk[i-3];
            tmp = tmp ^ rr(tmp, 1, w);
            rk[i] = (c ^ {63'h0, z[61 - ((i - mm) % 62)]} ^ rk[i-mm] ^ tmp) & msk;
        end
        for (int i = 0; i < 68; i++) kmem[i] = (i < nr) ? rk[i] : 64'h0;
        keys_valid = 1'b1;
    endtask

    task automatic model(input logic m, input logic e, input logic [63:0] xi, yi,
                         output logic [63:0] xo, yo);
        logic [63:0] msk, xx, yy, t;
        int w, nr;
        w = m ? 64 : 32;
        nr = m ? 68 : 44;
        msk = m ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        xx = xi & msk;
        yy = yi & msk;
        if (e) begin
            for (int i = 0; i < nr; i++) begin
                t = xx; xx = yy ^ ff(xx, w) ^ rk[i]; yy = t;
            end
        end else begin
            for (int i = nr - 1; i >= 0; i--) begin
                t = yy; yy = xx ^ ff(yy, w) ^ rk[i]; xx = t;
            end
        end
        xo = xx;
        yo = yy;
    endtask

    // Offers one block, follows it to out_valid, leaves out_ready low.
    // bad counts key_addr deviations from the saturating sequence and in_ready highs.
    task automatic drive_block(input logic m, input logic e, input logic [63:0] xi, yi,
                               output logic [63:0] xo, yo, output logic err,
                               output int lat, output int bad);
        int nr, g, exp_a;
        nr = m ? 68 : 44;
        bad = 0;
        lat = -1;
        xo = '0; yo = '0; err = 1'b0;
        @(negedge ck);
        mode = m; enc_dec = e; x_in = xi; y_in = yi; in_valid = 1'b1; out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge ck);
            g++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge ck); #1;
        in_valid = 1'b0;
        for (int j = 0; j <= 200; j++) begin
            if (out_valid) begin
                lat = j;
                break;
            end
            if (j <= nr) begin
                exp_a = e ? ((j < nr - 1) ? j : nr - 1) : ((nr - 1 - j > 0) ? nr - 1 - j : 0);
                if (key_addr !== 7'(exp_a)) bad++;
            end
            if (in_ready !== 1'b0) bad++;
            @(posedge ck); #1;
        end
        xo = x_out;
        yo = y_out;
        err = out_err;
    endtask

    task automatic release_out();
        @(negedge ck);
        out_ready = 1'b1;
        @(posedge ck); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge ck);
        #1;
        checks++;
        if ({in_ready, out_valid, out_err, key_addr, x_out, y_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b err=%b addr=%0d x=%h y=%h, required all zero",
                     in_ready, out_valid, out_err, key_addr, x_out, y_out);
        end
        checks++;
        if (out_valid2 !== 1'b0 || out_err2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_ns: vld=%b err=%b, required 0 0", out_valid2, out_err2);
        end
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic test_kat();
        logic [63:0] xo, yo;
        logic err;
        int lat, bad;
        load_keys(1'b0, 64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918);
        drive_block(1'b0, 1'b1, 64'h656b696c, 64'h20646e75, xo, yo, err, lat, bad);
        checks++;
        if ({xo, yo, err} !== {64'h44c8fc20, 64'hb9dfa07a, 1'b0}) begin
            errors++;
            $display("FAIL kat64_enc: got %h %h err=%b, required 44c8fc20 b9dfa07a err=0", xo, yo, err);
        end
        checks++;
        if (lat !== 45 || bad !== 0) begin
            errors++;
            $display("FAIL kat64_enc_timing: latency=%0d addr/ready_errs=%0d, required 45 0", lat, bad);
        end
        release_out();
        drive_block(1'b0, 1'b0, 64'h44c8fc20, 64'hb9dfa07a, xo, yo, err, lat, bad);
        checks++;
        if ({xo, yo} !== {64'h656b696c, 64'h20646e75} || lat !== 45 || bad !== 0) begin
            errors++;
            $display("FAIL kat64_dec: got %h %h lat=%0d bad=%0d, required 656b696c 20646e75 45 0", xo, yo, lat, bad);
        end
        release_out();
        load_keys(1'b1, 64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 64'h0, 64'h0);
        drive_block(1'b1, 1'b1, 64'h6373656420737265, 64'h6c6c657661727420, xo, yo, err, lat, bad);
        checks++;
        if ({xo, yo, err} !== {64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc, 1'b0}) begin
            errors++;
            $display("FAIL kat128_enc: got %h %h err=%b, required 49681b1e1e54fe3f 65aa832af84e0bbc err=0", xo, yo, err);
        end
        checks++;
        if (lat !== 69 || bad !== 0) begin
            errors++;
            $display("FAIL kat128_enc_timing: latency=%0d addr/ready_errs=%0d, required 69 0", lat, bad);
        end
        release_out();
        drive_block(1'b1, 1'b0, 64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc, xo, yo, err, lat, bad);
        checks++;
        if ({xo, yo} !== {64'h6373656420737265, 64'h6c6c657661727420} || lat !== 69 || bad !== 0) begin
            errors++;
            $display("FAIL kat128_dec: got %h %h lat=%0d bad=%0d, required plaintext 69 0", xo, yo, lat, bad);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [63:0] px, py, px2, py2, ex, ey, xo, yo;
        logic err;
        int lat, bad, unstable;
        px = {$urandom, $urandom}; py = {$urandom, $urandom};
        model(1'b1, 1'b1, px, py, ex, ey);
        drive_block(1'b1, 1'b1, px, py, xo, yo, err, lat, bad);
        checks++;
        if ({xo, yo} !== {ex, ey}) begin
            errors++;
            $display("FAIL bp_first: got %h %h, required %h %h", xo, yo, ex, ey);
        end
        px2 = {$urandom, $urandom}; py2 = {$urandom, $urandom};
        @(negedge ck);
        mode = 1'b1; enc_dec = 1'b1; x_in = px2; y_in = py2; in_valid = 1'b1;
        unstable = 0;
        repeat (20) begin
            @(negedge ck);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== ex || y_out !== ey) unstable++;
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", unstable);
        end
        out_ready = 1'b1;
        @(posedge ck); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_handoff: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        model(1'b1, 1'b1, px2, py2, ex, ey);
        drive_block(1'b1, 1'b1, px2, py2, xo, yo, err, lat, bad);
        checks++;
        if ({xo, yo} !== {ex, ey} || lat !== 69 || bad !== 0) begin
            errors++;
            $display("FAIL bp_second: got %h %h lat=%0d bad=%0d, required %h %h 69 0", xo, yo, lat, bad, ex, ey);
        end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] px, py, ex, ey, xo, yo;
        logic err;
        int lat, bad, g, spurious;
        px = {$urandom, $urandom}; py = {$urandom, $urandom};
        @(negedge ck);
        mode = 1'b1; enc_dec = 1'b0; x_in = px; y_in = py; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge ck);
            g++;
        end
        @(posedge ck); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge ck);
        @(negedge ck);
        rst = 1'b1;
        @(posedge ck); #1;
        checks++;
        if ({in_ready, out_valid, out_err, key_addr, x_out, y_out} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: rdy=%b vld=%b err=%b addr=%0d x=%h y=%h, required all zero",
                     in_ready, out_valid, out_err, key_addr, x_out, y_out);
        end
        @(negedge ck);
        rst = 1'b0;
        spurious = 0;
        repeat (80) begin
            @(posedge ck); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL midrun_no_output: out_valid high %0d cycles, required 0", spurious);
        end
        model(1'b1, 1'b0, px, py, ex, ey);
        drive_block(1'b1, 1'b0, px, py, xo, yo, err, lat, bad);
        checks++;
        if ({xo, yo} !== {ex, ey} || lat !== 69 || bad !== 0) begin
            errors++;
            $display("FAIL midrun_next: got %h %h lat=%0d bad=%0d, required %h %h 69 0", xo, yo, lat, bad, ex, ey);
        end
        release_out();
    endtask

    task automatic test_random();
        logic m;
        logic [63:0] px, py, ex, ey, xo, yo, dx, dy, pmx, pmy;
        logic err;
        int lat, bad, nr;
        for (int it = 0; it < 6; it++) begin
            m = 1'($urandom_range(0, 1));
            nr = m ? 68 : 44;
            load_keys(m, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            px = {$urandom, $urandom}; py = {$urandom, $urandom};
            model(m, 1'b1, px, py, ex, ey);
            drive_block(m, 1'b1, px, py, xo, yo, err, lat, bad);
            checks++;
            if ({xo, yo, err} !== {ex, ey, 1'b0} || lat !== nr + 1 || bad !== 0) begin
                errors++;
                $display("FAIL rand_enc[%0d] mode=%b: got %h %h err=%b lat=%0d bad=%0d, required %h %h 0 %0d 0",
                         it, m, xo, yo, err, lat, bad, ex, ey, nr + 1);
            end
            release_out();
            dx = m ? xo : {$urandom, xo[31:0]};
            dy = m ? yo : {$urandom, yo[31:0]};
            pmx = m ? px : {32'h0, px[31:0]};
            pmy = m ? py : {32'h0, py[31:0]};
            drive_block(m, 1'b0, dx, dy, xo, yo, err, lat, bad);
            checks++;
            if ({xo, yo} !== {pmx, pmy} || lat !== nr + 1 || bad !== 0) begin
                errors++;
                $display("FAIL rand_dec[%0d] mode=%b: got %h %h lat=%0d bad=%0d, required %h %h %0d 0",
                         it, m, xo, yo, lat, bad, pmx, pmy, nr + 1);
            end
            release_out();
        end
    endtask

    task automatic test_unsupported();
        @(negedge ck);
        keys_valid2 = 1'b0; mode2 = 1'b1; in_valid2 = 1'b1;
        x_in = 64'h0123456789abcdef; y_in = 64'hfedcba9876543210;
        repeat (3) @(negedge ck);
        checks++;
        if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL ns_no_keys: rdy=%b vld=%b, required 0 0", in_ready2, out_valid2);
        end
        keys_valid2 = 1'b1;
        #1;
        checks++;
        if (in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL ns_ready: rdy=%b, required 1", in_ready2);
        end
        @(posedge ck); #1;
        in_valid2 = 1'b0;
        checks++;
        if ({out_valid2, out_err2, x_out2, y_out2} !== {1'b1, 1'b1, 128'h0}) begin
            errors++;
            $display("FAIL ns_err: vld=%b err=%b x=%h y=%h, required 1 1 0 0", out_valid2, out_err2, x_out2, y_out2);
        end
        @(negedge ck);
        out_ready2 = 1'b1;
        @(posedge ck); #1;
        out_ready2 = 1'b0;
        checks++;
        if (out_valid2 !== 1'b0 || out_err2 !== 1'b0) begin
            errors++;
            $display("FAIL ns_clear: vld=%b err=%b, required 0 0", out_valid2, out_err2);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; enc_dec = 1'b1; x_in = '0; y_in = '0;
        in_valid = 1'b0; keys_valid = 1'b0; out_ready = 1'b0;
        mode2 = 1'b0; in_valid2 = 1'b0; keys_valid2 = 1'b0; out_ready2 = 1'b0;
        test_reset();
        test_kat();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_unsupported();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
